// File: rtl/linear_embedding_stream.sv
// Streaming patch projection: samples -> EMBED_DIM requantised int elements per token.
// Optional positional table enabled by defining LINEAR_EMBEDDING_POS_EN.
module linear_embedding_stream #(
    parameter int DATA_W     = 8,
    parameter int PATCH_LEN  = 1,
    parameter int NUM_TOKENS = 15,
    parameter int EMBED_DIM  = 16,
    parameter int ACC_W      = 24,
    parameter int SHIFT      = 7,
    localparam int DIM_W = (EMBED_DIM > 1) ? $clog2(EMBED_DIM) : 1,
    localparam int TOK_W = (NUM_TOKENS > 1) ? $clog2(NUM_TOKENS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     cfg_we,
    input  logic [1:0]               cfg_sel,
    input  logic [15:0]              cfg_addr,
    input  logic signed [DATA_W-1:0] cfg_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [DIM_W-1:0]         out_dim,
    output logic [TOK_W-1:0]         out_token,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int K_W  = (PATCH_LEN > 1) ? $clog2(PATCH_LEN) : 1;
    localparam int W_N  = PATCH_LEN * EMBED_DIM;
    localparam int WA_W = (W_N > 1) ? $clog2(W_N) : 1;
    localparam int RW   = ACC_W + 2;

    localparam logic signed [RW-1:0] RND   = RW'((1 << SHIFT) >> 1);
    localparam logic signed [RW-1:0] MAX_R = RW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [RW-1:0] MIN_R = -MAX_R - RW'(1);
    localparam logic [DATA_W-1:0] MAX_D = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_D = {1'b1, {(DATA_W - 1){1'b0}}};

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [TOK_W-1:0] t_q, t_d;
    logic [DIM_W-1:0] d_q, d_d;
    logic             done_q, done_d;

    logic signed [ACC_W-1:0]    acc_q [EMBED_DIM];
    logic signed [ACC_W-1:0]    acc_d [EMBED_DIM];
    logic signed [2*DATA_W-1:0] prod  [EMBED_DIM];

    logic signed [DATA_W-1:0] w_q [W_N];
    logic signed [DATA_W-1:0] b_q [EMBED_DIM];

    logic in_hs, out_hs, k_last, d_last, t_last, cfg_ok;
    logic signed [RW-1:0] acc_r, shifted;
    logic signed [DATA_W-1:0] sat_v;

    assign k_last = (k_q == K_W'(PATCH_LEN - 1));
    assign d_last = (d_q == DIM_W'(EMBED_DIM - 1));
    assign t_last = (t_q == TOK_W'(NUM_TOKENS - 1));

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DRAIN);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign busy      = (t_q != '0) || (k_q != '0) || (state_q == DRAIN);
    assign done      = done_q;
    assign out_dim   = d_q;
    assign out_token = t_q;
    assign out_last  = (state_q == DRAIN) && t_last && d_last;
    assign out_data  = (state_q == DRAIN) ? sat_v : '0;
    assign cfg_ok    = cfg_we && !busy;

    // Tables survive reset; only idle-time, in-range writes land.
    always_ff @(posedge clk) begin
        if (cfg_ok && cfg_sel == 2'd0 && cfg_addr < 16'(W_N))
            w_q[cfg_addr[WA_W-1:0]] <= cfg_data;
        if (cfg_ok && cfg_sel == 2'd1 && cfg_addr < 16'(EMBED_DIM))
            b_q[cfg_addr[DIM_W-1:0]] <= cfg_data;
    end

`ifdef LINEAR_EMBEDDING_POS_EN
    localparam int P_N  = NUM_TOKENS * EMBED_DIM;
    localparam int PA_W = (P_N > 1) ? $clog2(P_N) : 1;

    logic signed [DATA_W-1:0] p_q [P_N];
    logic [PA_W-1:0] p_idx;

    assign p_idx = PA_W'(int'(t_q) * EMBED_DIM + int'(d_q));

    always_ff @(posedge clk) begin
        if (cfg_ok && cfg_sel == 2'd2 && cfg_addr < 16'(P_N))
            p_q[cfg_addr[PA_W-1:0]] <= cfg_data;
    end
`endif

    always_comb begin
        acc_r   = RW'(acc_q[d_q]) + RND;
        shifted = acc_r >>> SHIFT;
`ifdef LINEAR_EMBEDDING_POS_EN
        shifted = shifted + RW'(p_q[p_idx]);
`endif
        if (shifted > MAX_R)
            sat_v = MAX_D;
        else if (shifted < MIN_R)
            sat_v = MIN_D;
        else
            sat_v = DATA_W'(shifted);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        t_d     = t_q;
        d_d     = d_q;
        done_d  = 1'b0;
        for (int i = 0; i < EMBED_DIM; i++) begin
            prod[i]  = in_data * w_q[WA_W'(int'(k_q) * EMBED_DIM + i)];
            acc_d[i] = acc_q[i];
        end
        unique case (state_q)
            ACCUM: begin
                if (in_hs) begin
                    // First sample of a patch reloads from bias.
                    for (int i = 0; i < EMBED_DIM; i++)
                        acc_d[i] = ((k_q == '0) ? ACC_W'(b_q[i]) : acc_q[i])
                                 + ACC_W'(prod[i]);
                    if (k_last) begin
                        k_d     = '0;
                        state_d = DRAIN;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    if (d_last) begin
                        d_d     = '0;
                        state_d = ACCUM;
                        if (t_last) begin
                            t_d    = '0;
                            done_d = 1'b1;
                        end else begin
                            t_d = t_q + 1'b1;
                        end
                    end else begin
                        d_d = d_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            k_q     <= '0;
            t_q     <= '0;
            d_q     <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < EMBED_DIM; i++)
                acc_q[i] <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            t_q     <= t_d;
            d_q     <= d_d;
            done_q  <= done_d;
            for (int i = 0; i < EMBED_DIM; i++)
                acc_q[i] <= acc_d[i];
        end
    end

endmodule
